// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control sequencer: states,
// opcodes, access sizes and the control-word bit layout used by the splitter.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        FETCH  = 4'd1,
        DECODE = 4'd2,
        EXEC   = 4'd3,
        MEM_RD = 4'd4,
        MEM_WR = 4'd5,
        WB     = 4'd6,
        BRANCH = 4'd7,
        JUMP   = 4'd8
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam int SIG_REG_DST    = 9;
    localparam int SIG_ALU_SRC    = 8;
    localparam int SIG_REG_WRITE  = 7;
    localparam int SIG_MEM_READ   = 6;
    localparam int SIG_MEM_WRITE  = 5;
    localparam int SIG_MEM_TO_REG = 4;
    localparam int SIG_BRANCH     = 3;
    localparam int SIG_JUMP       = 2;
    localparam int SIG_SIZE_MSB   = 1;
    localparam int SIG_SIZE_LSB   = 0;

    typedef struct packed {
        logic       is_rtype;
        logic       is_load;
        logic       is_store;
        logic       is_branch;
        logic       is_jump;
        logic       legal;
        logic [1:0] size;
    } op_info_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// Sequencer <-> datapath bundle: instruction fields and flags in, control out.
interface mc_control_fsm_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic [9:0]       signals;
    logic             pc_write;
    logic             ir_write;
    logic             i_or_d;
    logic             illegal_op;
    logic             mem_err;
    logic [CNT_W-1:0] instret;
    logic [3:0]       state_o;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output signals, pc_write, ir_write, i_or_d, illegal_op, mem_err,
               instret, state_o
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  signals, pc_write, ir_write, i_or_d, illegal_op, mem_err,
               instret, state_o
    );
endinterface

// File: rtl/mc_op_decode.sv
// Combinational opcode classifier: instruction class, legality and access size.
module mc_op_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0] op,
    output op_info_t   info
);

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
        info = '0;
        unique case (op)
            OP_RTYPE: begin info.is_rtype = 1'b1; info.legal = 1'b1; end
            OP_ADDI:  info.legal = 1'b1;
            OP_LW:    begin info.is_load  = 1'b1; info.legal = 1'b1; info.size = SIZE_WORD; end
            OP_LH:    begin info.is_load  = 1'b1; info.legal = 1'b1; info.size = SIZE_HALF; end
            OP_LB:    begin info.is_load  = 1'b1; info.legal = 1'b1; info.size = SIZE_BYTE; end
            OP_SW:    begin info.is_store = 1'b1; info.legal = 1'b1; info.size = SIZE_WORD; end
            OP_SH:    begin info.is_store = 1'b1; info.legal = 1'b1; info.size = SIZE_HALF; end
            OP_SB:    begin info.is_store = 1'b1; info.legal = 1'b1; info.size = SIZE_BYTE; end
            OP_BEQ:   begin info.is_branch = 1'b1; info.legal = 1'b1; end
            OP_J:     begin info.is_jump   = 1'b1; info.legal = 1'b1; end
            default:  info = '0;
        endcase
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control sequencer: fetch/decode/exec/mem/wb stepping with
// bounded memory waits and a retired-instruction counter.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input logic            clk,
    input logic            rst_n,
    mc_control_fsm_if.master bus
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0] instret_q;
    logic             retire;
    logic             in_mem;
    logic             timeout;
    logic [5:0]       dec_op;
    op_info_t         info;
    logic [9:0]       sig;

    wire unused_funct = ^bus.funct;

    // The live opcode is classified while in DECODE; later states use the latched copy.
    assign dec_op = (state_q == DECODE) ? bus.opcode : op_q;

    mc_op_decode u_op_decode (
        .op   (dec_op),
        .info (info)
    );

    assign in_mem  = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout = in_mem && !bus.mem_ready && (wait_q == WAIT_W'(MEM_TIMEOUT));

    always_comb begin
        state_d        = state_q;
        wait_d         = wait_q;
        sig            = '0;
        bus.pc_write   = 1'b0;
        bus.ir_write   = 1'b0;
        bus.i_or_d     = 1'b0;
        bus.illegal_op = 1'b0;
        bus.mem_err    = 1'b0;
        retire         = 1'b0;

        unique case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                sig[SIG_MEM_READ] = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                    state_d      = DECODE;
                end else if (timeout) begin
                    bus.mem_err = 1'b1;
                    state_d     = FETCH;
                end
            end
            DECODE: begin
                if (!info.legal) begin
                    bus.illegal_op = 1'b1;
                    state_d        = FETCH;
                end else if (info.is_branch) begin
                    state_d = BRANCH;
                end else if (info.is_jump) begin
                    state_d = JUMP;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sig[SIG_REG_DST] = info.is_rtype;
                sig[SIG_ALU_SRC] = !info.is_rtype;
                sig[SIG_SIZE_MSB:SIG_SIZE_LSB] = info.size;
                if (info.is_load)       state_d = MEM_RD;
                else if (info.is_store) state_d = MEM_WR;
                else                    state_d = WB;
            end
            MEM_RD: begin
                sig[SIG_ALU_SRC]  = 1'b1;
                sig[SIG_MEM_READ] = 1'b1;
                sig[SIG_SIZE_MSB:SIG_SIZE_LSB] = info.size;
                bus.i_or_d = 1'b1;
                if (bus.mem_ready) begin
                    state_d = WB;
                end else if (timeout) begin
                    bus.mem_err = 1'b1;
                    state_d     = FETCH;
                end
            end
            MEM_WR: begin
                sig[SIG_ALU_SRC]   = 1'b1;
                sig[SIG_MEM_WRITE] = 1'b1;
                sig[SIG_SIZE_MSB:SIG_SIZE_LSB] = info.size;
                bus.i_or_d = 1'b1;
                if (bus.mem_ready) begin
                    retire  = 1'b1;
                    state_d = FETCH;
                end else if (timeout) begin
                    bus.mem_err = 1'b1;
                    state_d     = FETCH;
                end
            end
            WB: begin
                sig[SIG_REG_WRITE]  = 1'b1;
                sig[SIG_REG_DST]    = info.is_rtype;
                sig[SIG_MEM_TO_REG] = info.is_load;
                sig[SIG_SIZE_MSB:SIG_SIZE_LSB] = info.size;
                retire  = 1'b1;
                state_d = FETCH;
            end
            BRANCH: begin
                sig[SIG_BRANCH] = 1'b1;
                bus.pc_write    = bus.zero;
                retire          = 1'b1;
                state_d         = FETCH;
            end
            JUMP: begin
                sig[SIG_JUMP] = 1'b1;
                bus.pc_write  = 1'b1;
                retire        = 1'b1;
                state_d       = FETCH;
            end
            default: state_d = IDLE;
        endcase

        // Entering (or re-entering after a timeout) a wait state restarts the budget.
        if (((state_d == FETCH) || (state_d == MEM_RD) || (state_d == MEM_WR)) &&
            ((state_d != state_q) || timeout)) begin
            wait_d = '0;
        end else if (in_mem && !bus.mem_ready) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            op_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            wait_q  <= wait_d;
            if (state_q == DECODE) op_q <= bus.opcode;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    assign bus.signals = sig;
    assign bus.instret = instret_q;
    assign bus.state_o = state_q;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
Multi-cycle control sequencer for the MIPS datapath. Each cycle it emits the packed 10-bit control word consumed by the existing control-word splitter, plus PC/IR enables and a memory-address select. It steps every instruction through fetch, decode, execute, memory and writeback states, and holds in the memory states until the memory handshake completes or times out. It also counts retired instructions.

Parameters:
MEM_TIMEOUT, 16, maximum cycles spent waiting in any memory state before abort (must be ≥1)
CNT_W, 32, width of the retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26]; sampled in DECODE
funct  in  6  IR[5:0]; informational only, not used for control
zero  in  1  ALU zero flag, sampled in BRANCH
mem_ready  in  1  memory completes the current request this cycle
signals  out  10  packed control word: [9]RegDst [8]ALUsrc [7]RegWrite [6]MemRead [5]MemWrite [4]MemToReg [3]Branch [2]Jump [1:0]size_in
pc_write  out  1  PC load enable
ir_write  out  1  IR load enable
i_or_d  out  1  memory address select: 0 = PC, 1 = ALU result
illegal_op  out  1  one-cycle pulse on an unsupported opcode
mem_err  out  1  one-cycle pulse on a memory-wait timeout
instret  out  CNT_W  retired-instruction count
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (async, rst_n=0): state=IDLE, wait counter=0, instret=0. All outputs are 0, including signals=10'b0.
- Outputs are a Moore decode of the state register plus the opcode latched in DECODE. The exceptions are pc_write and ir_write, which are Mealy-qualified by mem_ready or zero as stated below.
- size_in encoding: 00 = word, 01 = half, 10 = byte, 11 = reserved (never driven).
- Supported opcodes:
  - R-type 000000
  - addi 001000
  - lw 100011, lh 100001, lb 100000
  - sw 101011, sh 101001, sb 101000
  - beq 000100
  - j 000010
- IDLE: all outputs 0. Next state is FETCH unconditionally, one cycle after reset release.
- FETCH: MemRead=1, size=00, i_or_d=0.
  - If mem_ready=1: ir_write=1 and pc_write=1 (PC+4) in the same cycle, next state DECODE.
  - Otherwise stay in FETCH.
- DECODE: control word all 0. Latch opcode into op_q.
  - R-type, addi, loads and stores → EXEC.
  - beq → BRANCH.
  - j → JUMP.
  - Any other opcode → FETCH, with illegal_op=1 this cycle. instret is not incremented.
- EXEC (1 cycle):
  - R-type: RegDst=1, ALUsrc=0.
  - All other opcodes: ALUsrc=1.
  - Next: R-type/addi → WB; loads → MEM_RD; stores → MEM_WR.
- MEM_RD: MemRead=1, i_or_d=1, size from op_q. Hold until mem_ready=1, then WB.
- MEM_WR: MemWrite=1, i_or_d=1, size from op_q. Hold until mem_ready=1, then FETCH with instret+1.
- WB:
  - RegWrite=1 for all opcodes that reach WB.
  - RegDst=1 for R-type only.
  - MemToReg=1 for loads only.
  - Next FETCH, instret+1.
- BRANCH: Branch=1, pc_write=zero. Next FETCH, instret+1.
- JUMP: Jump=1, pc_write=1. Next FETCH, instret+1.
- Memory wait counter:
  - Clears on entry to FETCH, MEM_RD or MEM_WR.
  - Increments each cycle in those states while mem_ready=0.
  - If the counter reaches MEM_TIMEOUT with mem_ready still 0: mem_err=1 for that cycle, next state FETCH, no PC/IR write, instret unchanged.
  - mem_ready=1 on the same cycle as the timeout wins: normal completion, no mem_err.
- instret wraps modulo 2^CNT_W.
- Reset mid-instruction aborts immediately. No partial write is ever signalled after rst_n falls.
- MemRead and MemWrite are never both 1. RegWrite is never 1 in a memory state.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - state enum: IDLE, FETCH, DECODE, EXEC, MEM_RD, MEM_WR, WB, BRANCH, JUMP;
  - opcode constants;
  - SIZE_WORD, SIZE_HALF, SIZE_BYTE;
  - control-word bit-index constants, which the existing splitter also uses.
- One natural sub-module: mc_op_decode. It is combinational and maps op_q to {is_rtype, is_load, is_store, is_branch, is_jump, legal, size}.

Test Plan:
- Reset, then rst_n=1 with mem_ready tied 1 and opcode=000000 → state sequence IDLE, FETCH, DECODE, EXEC, WB, FETCH; WB signals=10'b1010000000; instret=1.
- lb (100000) with mem_ready=1 in FETCH and low for 3 cycles in MEM_RD → MEM_RD signals=10'b0101000010 held for 4 cycles; then WB signals=10'b0010010010.
- sh (101001) → MEM_WR signals=10'b0100100001; RegWrite never 1; FETCH follows; instret increments by 1.
- beq with zero=0, then beq with zero=1 → BRANCH signals=10'b0000001000 both times; pc_write=0 for the first and 1 for the second.
- opcode=111111 → illegal_op pulses in the DECODE cycle; next state FETCH; instret unchanged.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 → mem_err pulses after 16 wait cycles; ir_write never asserted; state returns to FETCH. Then drop rst_n mid-MEM_WR → signals=0 immediately.
